// File: rtl/hls_run_pkg.sv
// Shared types and default widths for the HLS run controller.
// Optional watchdog is enabled by defining HLS_RUN_TIMEOUT_EN.
package hls_run_pkg;

    localparam int DW_DEF    = 128;
    localparam int CNT_W_DEF = 32;
    localparam int TO_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DRAIN
    } run_state_e;

endpackage

// File: rtl/hls_gate_cnt.sv
// Word counter with limit compare; opens a stream gate while below
// the limit latched at run start.
module hls_gate_cnt
    import hls_run_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    input  logic             run,
    input  logic             fifo_ok,
    input  logic             strb,
    output logic             gate_open,
    output logic             fire,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] lim_q;

    // Gate closes the same cycle the count reaches the limit,
    // so the counter can never pass it.
    assign gate_open = run & (count < lim_q);
    assign fire      = strb & fifo_ok & gate_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim_q <= '0;
            count <= '0;
        end else if (clr) begin
            lim_q <= limit;
            count <= '0;
        end else if (fire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hls_run_ctrl.sv
// Sequences one HLS kernel run and gates both streams to the programmed
// word counts. Define HLS_RUN_TIMEOUT_EN to build in the run watchdog.
module hls_run_ctrl
    import hls_run_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic             ip_clk,
    input  logic             ip_rst_n,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_in_words,
    input  logic [CNT_W-1:0] cfg_out_words,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic [DW-1:0]    in_r_dout,
    input  logic             in_r_empty_n,
    output logic             in_r_read,
    output logic [DW-1:0]    out_r_din,
    input  logic             out_r_full,
    output logic             out_r_write,
    output logic [DW-1:0]    k_in_dout,
    output logic             k_in_empty_n,
    input  logic             k_in_read,
    input  logic [DW-1:0]    k_out_din,
    output logic             k_out_full,
    input  logic             k_out_write,
    output logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);

    run_state_e state;
    logic       accept;
    logic       run_open;
    logic       abort;
    logic       in_open;
    logic       in_fire;
    logic       out_open;
    logic       out_fire;

    assign accept   = (state == IDLE) & cfg_start & ap_idle;
    assign run_open = (state == RUN) & ~abort;

    hls_gate_cnt #(
        .CNT_W (CNT_W)
    ) u_in_gate (
        .clk       (ip_clk),
        .rst_n     (ip_rst_n),
        .clr       (accept),
        .limit     (cfg_in_words),
        .run       (run_open),
        .fifo_ok   (in_r_empty_n),
        .strb      (k_in_read),
        .gate_open (in_open),
        .fire      (in_fire),
        .count     (in_count)
    );

    hls_gate_cnt #(
        .CNT_W (CNT_W)
    ) u_out_gate (
        .clk       (ip_clk),
        .rst_n     (ip_rst_n),
        .clr       (accept),
        .limit     (cfg_out_words),
        .run       (run_open),
        .fifo_ok   (~out_r_full),
        .strb      (k_out_write),
        .gate_open (out_open),
        .fire      (out_fire),
        .count     (out_count)
    );

    assign k_in_dout    = in_r_dout;
    assign k_in_empty_n = in_r_empty_n & in_open;
    assign in_r_read    = in_fire;

    assign out_r_din    = k_out_din;
    assign k_out_full   = out_r_full | ~out_open;
    assign out_r_write  = out_fire;

`ifdef HLS_RUN_TIMEOUT_EN
    logic [TO_W-1:0] to_lim;
    logic [TO_W-1:0] wdog;
    logic            wdog_on;
    logic            to_q;

    assign wdog_on = (state == START) | (state == RUN);
    assign abort   = wdog_on & (to_lim != '0)
                   & (TO_W'(wdog + 1'b1) == to_lim);
    assign timeout = to_q;

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            to_lim <= '0;
            wdog   <= '0;
            to_q   <= 1'b0;
        end else if (accept) begin
            to_lim <= cfg_timeout;
            wdog   <= '0;
            to_q   <= 1'b0;
        end else begin
            if (wdog_on)
                wdog <= wdog + 1'b1;
            if (abort)
                to_q <= 1'b1;
        end
    end
`else
    logic unused_cfg_timeout;

    assign unused_cfg_timeout = ^cfg_timeout;
    assign abort              = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state    <= IDLE;
            ap_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            ap_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= START;
                        ap_start <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                START: begin
                    // Kernel acknowledges start by dropping ap_idle.
                    if (!ap_idle)
                        state <= RUN;
                end
                RUN: begin
                    if (ap_done) begin
                        state    <= DRAIN;
                        ap_start <= 1'b0;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Directed and randomized checks of hls_run_ctrl against a
// word-quota model of the gated stream path.
module tb_hls_run_ctrl;

    localparam int DW    = 128;
    localparam int CNT_W = 32;
    localparam int TO_W  = 32;

    logic             ip_clk;
    logic             ip_rst_n;
    logic             cfg_start;
    logic [CNT_W-1:0] cfg_in_words;
    logic [CNT_W-1:0] cfg_out_words;
    logic [TO_W-1:0]  cfg_timeout;
    logic [DW-1:0]    in_r_dout;
    logic             in_r_empty_n;
    logic             in_r_read;
    logic [DW-1:0]    out_r_din;
    logic             out_r_full;
    logic             out_r_write;
    logic [DW-1:0]    k_in_dout;
    logic             k_in_empty_n;
    logic             k_in_read;
    logic [DW-1:0]    k_out_din;
    logic             k_out_full;
    logic             k_out_write;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;

    int checks;
    int errors;
    int lim_in;
    int lim_out;
    int exp_in;
    int exp_out;
    int n_rd;
    int n_wr;
    bit running;

    hls_run_ctrl dut (
        .ip_clk        (ip_clk),
        .ip_rst_n      (ip_rst_n),
        .cfg_start     (cfg_start),
        .cfg_in_words  (cfg_in_words),
        .cfg_out_words (cfg_out_words),
        .cfg_timeout   (cfg_timeout),
        .in_r_dout     (in_r_dout),
        .in_r_empty_n  (in_r_empty_n),
        .in_r_read     (in_r_read),
        .out_r_din     (out_r_din),
        .out_r_full    (out_r_full),
        .out_r_write   (out_r_write),
        .k_in_dout     (k_in_dout),
        .k_in_empty_n  (k_in_empty_n),
        .k_in_read     (k_in_read),
        .k_out_din     (k_out_din),
        .k_out_full    (k_out_full),
        .k_out_write   (k_out_write),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .in_count      (in_count),
        .out_count     (out_count)
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    task automatic chk(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // One cycle of kernel/FIFO activity; the model grants a word only
    // while the run is active and the quota is not yet used up.
    task automatic cyc(input bit rd, input bit en,
                       input bit wr, input bit full);
        bit in_ok;
        bit out_ok;
        bit e_rd;
        bit e_wr;
        k_in_read    = rd;
        in_r_empty_n = en;
        k_out_write  = wr;
        out_r_full   = full;
        in_r_dout    = {$urandom, $urandom, $urandom, $urandom};
        k_out_din    = {$urandom, $urandom, $urandom, $urandom};
        #1;
        in_ok  = running && (exp_in < lim_in);
        out_ok = running && (exp_out < lim_out);
        e_rd   = in_ok && en && rd;
        e_wr   = out_ok && !full && wr;
        chk("k_in_empty_n", k_in_empty_n, in_ok && en);
        chk("in_r_read", in_r_read, e_rd);
        chk("k_out_full", k_out_full, full || !out_ok);
        chk("out_r_write", out_r_write, e_wr);
        chk("k_in_dout", k_in_dout, in_r_dout);
        chk("out_r_din", out_r_din, k_out_din);
        chk("ap_start", ap_start, running);
        n_rd += int'(in_r_read);
        n_wr += int'(out_r_write);
        @(posedge ip_clk);
        #1;
        if (e_rd) exp_in++;
        if (e_wr) exp_out++;
        chk("in_count", in_count, exp_in);
        chk("out_count", out_count, exp_out);
    endtask

    task automatic start_run(input int ci, input int co);
        cfg_in_words  = ci;
        cfg_out_words = co;
        ap_idle       = 1'b1;
        cfg_start     = 1'b1;
        k_in_read     = 1'b0;
        k_out_write   = 1'b0;
        @(posedge ip_clk);
        #1;
        cfg_start     = 1'b0;
        cfg_in_words  = '1;
        cfg_out_words = '1;
        lim_in  = ci;
        lim_out = co;
        exp_in  = 0;
        exp_out = 0;
        n_rd    = 0;
        n_wr    = 0;
        chk("start.ap_start", ap_start, 1);
        chk("start.busy", busy, 1);
        chk("start.done", done, 0);
        chk("start.in_count", in_count, 0);
        chk("start.out_count", out_count, 0);
        k_in_read    = 1'b1;
        in_r_empty_n = 1'b1;
        ap_idle      = 1'b0;
        #1;
        chk("start.gate_closed", k_in_empty_n, 0);
        @(posedge ip_clk);
        #1;
        k_in_read = 1'b0;
        running   = 1'b1;
    endtask

    task automatic finish_run();
        ap_done = 1'b1;
        cyc(1'($urandom), 1'b1, 1'($urandom), 1'b0);
        ap_done = 1'b0;
        ap_idle = 1'b1;
        running = 1'b0;
        chk("drain.ap_start", ap_start, 0);
        chk("drain.busy", busy, 1);
        chk("drain.done", done, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("end.busy", busy, 0);
        chk("end.done", done, 1);
        chk("end.ap_start", ap_start, 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        running       = 1'b0;
        lim_in        = 0;
        lim_out       = 0;
        exp_in        = 0;
        exp_out       = 0;
        n_rd          = 0;
        n_wr          = 0;
        ip_rst_n      = 1'b0;
        cfg_start     = 1'b0;
        cfg_in_words  = '0;
        cfg_out_words = '0;
        cfg_timeout   = '0;
        in_r_dout     = '0;
        in_r_empty_n  = 1'b1;
        out_r_full    = 1'b0;
        k_in_read     = 1'b1;
        k_out_din     = '0;
        k_out_write   = 1'b1;
        ap_done       = 1'b0;
        ap_idle       = 1'b1;

        repeat (2) @(posedge ip_clk);
        #1;
        chk("rst.ap_start", ap_start, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.in_count", in_count, 0);
        chk("rst.out_count", out_count, 0);
        chk("rst.k_in_empty_n", k_in_empty_n, 0);
        chk("rst.k_out_full", k_out_full, 1);
        chk("rst.in_r_read", in_r_read, 0);
        ip_rst_n = 1'b1;
        @(posedge ip_clk);
        #1;

        // 4 in / 2 out quota against 6 reads and 3 writes.
        start_run(4, 2);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b1, i < 3, 1'b0);
        finish_run();
        chk("q42.n_rd", n_rd, 4);
        chk("q42.n_wr", n_wr, 2);
        chk("q42.in_count", in_count, 4);
        chk("q42.out_count", out_count, 2);

        // Host FIFO empty for 10 cycles mid-run.
        start_run(4, 1);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("starve.in_count", in_count, 2);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        finish_run();
        chk("starve.final", in_count, 4);

        // Zero input quota plus a start pulse while busy.
        start_run(0, 3);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cfg_in_words  = 7;
        cfg_out_words = 9;
        cfg_start     = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cfg_start = 1'b0;
        chk("busy_start.busy", busy, 1);
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        finish_run();
        chk("zero.in_count", in_count, 0);
        chk("zero.out_count", out_count, 3);

        // Start ignored while the kernel is not idle.
        ap_idle   = 1'b0;
        cfg_start = 1'b1;
        @(posedge ip_clk);
        #1;
        cfg_start = 1'b0;
        ap_idle   = 1'b1;
        chk("notidle.busy", busy, 0);
        chk("notidle.ap_start", ap_start, 0);
        chk("notidle.done", done, 1);

        // Output FIFO full while the kernel writes.
        start_run(2, 2);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("full.out_count", out_count, 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        finish_run();
        chk("full.final", out_count, 2);

        // Asynchronous reset in the middle of RUN.
        start_run(5, 5);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        k_in_read    = 1'b1;
        in_r_empty_n = 1'b1;
        #2;
        ip_rst_n = 1'b0;
        #1;
        running = 1'b0;
        chk("midrst.ap_start", ap_start, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.in_count", in_count, 0);
        chk("midrst.out_count", out_count, 0);
        chk("midrst.k_in_empty_n", k_in_empty_n, 0);
        #1;
        ip_rst_n = 1'b1;
        @(posedge ip_clk);
        #1;
        chk("midrst.idle_busy", busy, 0);
        chk("midrst.idle_done", done, 0);

`ifdef HLS_RUN_TIMEOUT_EN
        cfg_timeout = 50;
        start_run(3, 3);
        running     = 1'b0;
        k_in_read   = 1'b0;
        k_out_write = 1'b0;
        cfg_timeout = '0;
        for (int i = 0; i < 48; i++) begin
            @(posedge ip_clk);
            #1;
            chk("wdog.pre", timeout, 0);
        end
        @(posedge ip_clk);
        #1;
        chk("wdog.timeout", timeout, 1);
        chk("wdog.done", done, 0);
        chk("wdog.ap_start", ap_start, 0);
        chk("wdog.busy", busy, 0);
        ap_idle = 1'b1;
`endif

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            start_run($urandom_range(0, 8), $urandom_range(0, 8));
            repeat (25)
                cyc(1'($urandom), ($urandom % 4) != 0,
                    1'($urandom), ($urandom % 4) == 0);
            finish_run();
            chk("rand.n_rd", n_rd, exp_in);
            chk("rand.n_wr", n_wr, exp_out);
            chk("rand.timeout", timeout, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
